// File: rtl/aes_128_stim_seq_pkg.sv
// Shared types and constants for the aes_128 stimulus sequencer.
// LFSR polynomial x^128+x^126+x^101+x^99+1, Fibonacci, shift left.
package aes_stim_pkg;

  localparam int DEF_DATA_W  = 128;
  localparam int DEF_LATENCY = 21;
  localparam int DEF_CNT_W   = 32;

  localparam int TAP_A = 127;
  localparam int TAP_B = 125;
  localparam int TAP_C = 100;
  localparam int TAP_D = 98;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } stim_state_t;

  function automatic logic [DEF_DATA_W-1:0] lfsr_step(
    input logic [DEF_DATA_W-1:0] cur
  );
    return {cur[DEF_DATA_W-2:0],
            cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};
  endfunction

  // An all-zero LFSR never leaves zero, so it is nudged to 1.
  function automatic logic [DEF_DATA_W-1:0] seed_fix(
    input logic [DEF_DATA_W-1:0] s
  );
    return (s == '0) ? {{(DEF_DATA_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/aes_128_stim_seq_if.sv
// Control, aes_128 link and result bundle of the stimulus sequencer.
// slave = sequencer side, master = environment/controller side.
interface aes_128_stim_seq_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [CNT_W-1:0]  num_tests;
  logic [DATA_W-1:0] state_seed;
  logic [DATA_W-1:0] key_seed;
  logic [DATA_W-1:0] aes_state;
  logic [DATA_W-1:0] aes_key;
  logic [DATA_W-1:0] aes_out;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_state;
  logic [DATA_W-1:0] out_key;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  completed;
  logic              busy;
  logic              done;

  modport slave (
    input  start, num_tests, state_seed, key_seed, aes_out,
    output aes_state, aes_key, out_valid, out_data,
           out_state, out_key, issued, completed, busy, done
  );

  modport master (
    output start, num_tests, state_seed, key_seed, aes_out,
    input  aes_state, aes_key, out_valid, out_data,
           out_state, out_key, issued, completed, busy, done
  );
endinterface

// File: rtl/aes_128_stim_seq_delay_line.sv
// Fixed-depth data delay, no reset: validity is tracked by the parent.
// Carries {plaintext,key} alongside the aes_128 pipeline.
module aes_delay_line #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 21
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    pipe[0] <= din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/aes_128_stim_seq.sv
// LFSR plaintext/key generator feeding aes_128, with a valid pipeline
// matching the core latency and issue/complete counters.
module aes_128_stim_seq
  import aes_stim_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  aes_128_stim_seq_if.slave bus
);
  stim_state_t state, state_nxt;

  logic [CNT_W-1:0]    n_tests;
  logic [CNT_W-1:0]    issued;
  logic [CNT_W-1:0]    completed;
  logic [CNT_W-1:0]    issued_inc;
  logic [CNT_W-1:0]    completed_inc;
  logic [DATA_W-1:0]   pt;
  logic [DATA_W-1:0]   key;
  logic [LATENCY-1:0]  vld;
  logic [2*DATA_W-1:0] dl_out;
  logic                accept;
  logic                issue;
  logic                last_issue;
  logic                ovalid;

  assign ovalid = vld[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    issue         = 1'b0;
    issued_inc    = issued + CNT_W'(1);
    completed_inc = completed + CNT_W'(ovalid);
    last_issue    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.num_tests == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        issue      = 1'b1;
        last_issue = (issued_inc == n_tests);
        if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (completed_inc == n_tests) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_tests   <= '0;
      issued    <= '0;
      completed <= '0;
      pt        <= '0;
      key       <= '0;
      vld       <= '0;
    end else begin
      vld <= {vld[LATENCY-2:0], issue};
      if (accept) begin
        n_tests   <= bus.num_tests;
        pt        <= seed_fix(bus.state_seed);
        key       <= seed_fix(bus.key_seed);
        issued    <= '0;
        completed <= '0;
      end else begin
        completed <= completed_inc;
        if (issue) begin
          issued <= issued_inc;
          if (!last_issue) begin
            pt  <= lfsr_step(pt);
            key <= lfsr_step(key);
          end
        end
      end
    end
  end

  aes_delay_line #(
    .WIDTH (2*DATA_W),
    .DEPTH (LATENCY)
  ) u_dly (
    .clk  (clk),
    .din  ({pt, key}),
    .dout (dl_out)
  );

  // Result fields read as zero outside valid cycles, including after reset.
  assign bus.aes_state = pt;
  assign bus.aes_key   = key;
  assign bus.out_valid = ovalid;
  assign bus.out_data  = ovalid ? bus.aes_out : '0;
  assign bus.out_state = ovalid ? dl_out[2*DATA_W-1:DATA_W] : '0;
  assign bus.out_key   = ovalid ? dl_out[DATA_W-1:0] : '0;
  assign bus.issued    = issued;
  assign bus.completed = completed;
  assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done      = (state == S_DONE);
endmodule
